// File: rtl/bus_arbiter.sv
// Two-master system-bus arbiter with stall timeout abort.
// Define BUS_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_valid,
  input  logic        m0_wen,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_valid,
  input  logic        m1_wen,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  output logic        bus_valid,
  output logic        bus_wen,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic [1:0]  gnt,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  localparam logic [15:0] TO_CNT     = 16'(TIMEOUT_CYC);
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_gnt;
  logic [1:0]  w_gnt_nxt;
  logic [15:0] r_stall;
  logic [15:0] w_stall_nxt;
  logic        w_prefer1;
  logic        w_granted;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wmask;
  logic        w_sel_valid;
  logic        w_sel_wen;

  // Contention resolver: prefer1 breaks a tie in favour of master 1.
  function automatic state_t f_pick(input logic v0, input logic v1, input logic prefer1);
    state_t s;
    if (v0 && v1) begin
      s = prefer1 ? GRANT1 : GRANT0;
    end else if (v0) begin
      s = GRANT0;
    end else if (v1) begin
      s = GRANT1;
    end else begin
      s = IDLE;
    end
    return s;
  endfunction

  // Request fields of the currently granted master (all zero when idle).
  always_comb begin
    w_sel_addr  = 32'd0;
    w_sel_wdata = 32'd0;
    w_sel_wmask = 4'd0;
    w_sel_valid = 1'b0;
    w_sel_wen   = 1'b0;
    case (r_state)
      GRANT0: begin
        w_sel_addr  = m0_addr;
        w_sel_wdata = m0_wdata;
        w_sel_wmask = m0_wmask;
        w_sel_valid = m0_valid;
        w_sel_wen   = m0_wen;
      end
      GRANT1: begin
        w_sel_addr  = m1_addr;
        w_sel_wdata = m1_wdata;
        w_sel_wmask = m1_wmask;
        w_sel_valid = m1_valid;
        w_sel_wen   = m1_wen;
      end
      default: begin
        w_sel_addr  = 32'd0;
        w_sel_wdata = 32'd0;
        w_sel_wmask = 4'd0;
        w_sel_valid = 1'b0;
        w_sel_wen   = 1'b0;
      end
    endcase
  end

  assign w_granted = (r_state != IDLE);
  // Reset cycle suppresses the abort so an interrupted transfer sees no pulse.
  assign w_timeout = w_granted && w_sel_valid && (r_stall == TO_CNT) && !rst;
  assign w_done    = w_timeout || (w_granted && w_sel_valid && bus_ready);

`ifdef BUS_ARB_RR_EN
  logic r_last;

  // Tie-break: idle favours the master not served last; at completion the other master.
  always_comb begin
    w_prefer1 = 1'b0;
    case (r_state)
      IDLE:    w_prefer1 = ~r_last;
      GRANT0:  w_prefer1 = 1'b1;
      GRANT1:  w_prefer1 = 1'b0;
      default: w_prefer1 = 1'b0;
    endcase
  end

  // Last-served pointer follows every new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_state_nxt == GRANT0) begin
      r_last <= 1'b0;
    end else if (w_state_nxt == GRANT1) begin
      r_last <= 1'b1;
    end else begin
      r_last <= r_last;
    end
  end
`else
  assign w_prefer1 = 1'b0;
`endif

  // Next-state: stalled grants are held; completion or abort re-arbitrates.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: w_state_nxt = f_pick(m0_valid, m1_valid, w_prefer1);
      GRANT0, GRANT1: begin
        if (w_done) begin
          w_state_nxt = f_pick(m0_valid, m1_valid, w_prefer1);
        end else if (!w_sel_valid) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant vector and saturating stall counter for the next cycle.
  always_comb begin
    w_gnt_nxt   = 2'b00;
    w_stall_nxt = 16'd0;
    case (w_state_nxt)
      GRANT0:  w_gnt_nxt = 2'b01;
      GRANT1:  w_gnt_nxt = 2'b10;
      default: w_gnt_nxt = 2'b00;
    endcase
    if (!w_granted || w_done || (w_state_nxt != r_state)) begin
      w_stall_nxt = 16'd0;
    end else if (w_sel_valid && !bus_ready && (r_stall != 16'hFFFF)) begin
      w_stall_nxt = r_stall + 16'd1;
    end else begin
      w_stall_nxt = r_stall;
    end
  end

  // State, grant and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_stall <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_stall <= w_stall_nxt;
    end
  end

  // Bus forwarding and master responses; an abort answers locally with ABORT_DATA.
  always_comb begin
    bus_addr    = w_sel_addr;
    bus_wdata   = w_sel_wdata;
    bus_wmask   = w_sel_wmask;
    bus_valid   = w_sel_valid && !w_timeout;
    bus_wen     = w_sel_wen && w_sel_valid && !w_timeout;
    timeout_err = w_timeout;
    m0_ready    = 1'b0;
    m0_rdata    = 32'd0;
    m1_ready    = 1'b0;
    m1_rdata    = 32'd0;
    if (r_state == GRANT0) begin
      m0_ready = !rst && (w_timeout || bus_ready);
      m0_rdata = w_timeout ? ABORT_DATA : bus_rdata;
    end else if (r_state == GRANT1) begin
      m1_ready = !rst && (w_timeout || bus_ready);
      m1_rdata = w_timeout ? ABORT_DATA : bus_rdata;
    end else begin
      m0_ready = 1'b0;
      m1_ready = 1'b0;
    end
  end

  assign gnt = r_gnt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two instances (default timeout and timeout 4) checked against a rule-level model.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m1_addr = 32'd0, m1_wdata = 32'd0;
  logic [3:0]  m0_wmask = 4'd0, m1_wmask = 4'd0;
  logic        m0_valid = 1'b0, m0_wen = 1'b0, m1_valid = 1'b0, m1_wen = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ready = 1'b0;

  logic [31:0] o_m0_rdata [2];
  logic        o_m0_ready [2];
  logic [31:0] o_m1_rdata [2];
  logic        o_m1_ready [2];
  logic [31:0] o_bus_addr [2];
  logic [31:0] o_bus_wdata [2];
  logic [3:0]  o_bus_wmask [2];
  logic        o_bus_valid [2];
  logic        o_bus_wen [2];
  logic [1:0]  o_gnt [2];
  logic        o_tout [2];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  // model state: granted master (-1 = none), stall count, last served
  int mg [2]    = '{-1, -1};
  int mstall [2] = '{0, 0};
  int mlast [2] = '{1, 1};
  int tov [2]   = '{255, 4};

  always #5 clk = ~clk;

  bus_arbiter u_dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_valid(m0_valid), .m0_wen(m0_wen),
    .m0_rdata(o_m0_rdata[0]), .m0_ready(o_m0_ready[0]),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_valid(m1_valid), .m1_wen(m1_wen),
    .m1_rdata(o_m1_rdata[0]), .m1_ready(o_m1_ready[0]),
    .bus_addr(o_bus_addr[0]), .bus_wdata(o_bus_wdata[0]), .bus_wmask(o_bus_wmask[0]),
    .bus_valid(o_bus_valid[0]), .bus_wen(o_bus_wen[0]),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .gnt(o_gnt[0]), .timeout_err(o_tout[0])
  );

  bus_arbiter #(.TIMEOUT_CYC(4)) u_dut_to4 (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_valid(m0_valid), .m0_wen(m0_wen),
    .m0_rdata(o_m0_rdata[1]), .m0_ready(o_m0_ready[1]),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_valid(m1_valid), .m1_wen(m1_wen),
    .m1_rdata(o_m1_rdata[1]), .m1_ready(o_m1_ready[1]),
    .bus_addr(o_bus_addr[1]), .bus_wdata(o_bus_wdata[1]), .bus_wmask(o_bus_wmask[1]),
    .bus_valid(o_bus_valid[1]), .bus_wen(o_bus_wen[1]),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .gnt(o_gnt[1]), .timeout_err(o_tout[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit granted_valid(input int g);
    return (g == 0) ? m0_valid : ((g == 1) ? m1_valid : 1'b0);
  endfunction

  function automatic bit exp_timeout(input int k);
    return (mg[k] >= 0) && granted_valid(mg[k]) && (mstall[k] == tov[k]) && !rst;
  endfunction

  // who gets the bus when arbitration happens (g = master just served, -1 from idle)
  function automatic int pick(input int k, input int g);
`ifdef BUS_ARB_RR_EN
    if (m0_valid && m1_valid) return (g < 0) ? (1 - mlast[k]) : (1 - g);
`else
    if (m0_valid && m1_valid) return 0;
`endif
    if (m0_valid) return 0;
    if (m1_valid) return 1;
    return -1;
  endfunction

  task automatic model_step(input int k);
    int g, ng;
    bit gv, done;
    g = mg[k];
    if (rst) begin
      mg[k] = -1; mstall[k] = 0; mlast[k] = 1;
      return;
    end
    gv   = granted_valid(g);
    done = exp_timeout(k) || ((g >= 0) && gv && bus_ready);
    if (g < 0 || done) ng = pick(k, g);
    else if (!gv)      ng = -1;
    else               ng = g;
    if (ng != g || done || ng < 0) mstall[k] = 0;
    else if (mstall[k] < 65535)    mstall[k] = mstall[k] + 1;
    if (ng >= 0) mlast[k] = ng;
    mg[k] = ng;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic cmp(input int k);
    int g;
    bit to, gv;
    logic [31:0] ga, gd;
    logic [3:0] gm;
    bit gw;
    g  = mg[k];
    to = exp_timeout(k);
    gv = granted_valid(g);
    ga = (g == 0) ? m0_addr  : ((g == 1) ? m1_addr  : 32'd0);
    gd = (g == 0) ? m0_wdata : ((g == 1) ? m1_wdata : 32'd0);
    gm = (g == 0) ? m0_wmask : ((g == 1) ? m1_wmask : 4'd0);
    gw = (g == 0) ? m0_wen   : ((g == 1) ? m1_wen   : 1'b0);
    chk($sformatf("gnt[%0d]", k), o_gnt[k], (g < 0) ? 32'd0 : (32'd1 << g));
    chk($sformatf("bus_valid[%0d]", k), o_bus_valid[k], (gv && !to) ? 32'd1 : 32'd0);
    chk($sformatf("bus_wen[%0d]", k), o_bus_wen[k], (gv && gw && !to) ? 32'd1 : 32'd0);
    chk($sformatf("bus_addr[%0d]", k), o_bus_addr[k], ga);
    chk($sformatf("bus_wdata[%0d]", k), o_bus_wdata[k], gd);
    chk($sformatf("bus_wmask[%0d]", k), o_bus_wmask[k], 32'(gm));
    chk($sformatf("m0_ready[%0d]", k), o_m0_ready[k], ((g == 0) && !rst && (to || bus_ready)) ? 32'd1 : 32'd0);
    chk($sformatf("m1_ready[%0d]", k), o_m1_ready[k], ((g == 1) && !rst && (to || bus_ready)) ? 32'd1 : 32'd0);
    chk($sformatf("m0_rdata[%0d]", k), o_m0_rdata[k], (g == 0) ? (to ? 32'hDEAD_BEEF : bus_rdata) : 32'd0);
    chk($sformatf("m1_rdata[%0d]", k), o_m1_rdata[k], (g == 1) ? (to ? 32'hDEAD_BEEF : bus_rdata) : 32'd0);
    chk($sformatf("timeout_err[%0d]", k), o_tout[k], to ? 32'd1 : 32'd0);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) cmp(k);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m1_valid = 1'b0; m0_wen = 1'b0; m1_wen = 1'b0;
    bus_ready = 1'b0; bus_rdata = 32'd0;
  endtask

  task automatic do_reset();
    cyc();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cmp_en = 1'b1;
  endtask

  logic [1:0] exp_seq [4];

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_gnt", o_gnt[0], 32'd0);
    chk("rst_bus_valid", o_bus_valid[0], 32'd0);
    chk("rst_bus_addr", o_bus_addr[0], 32'd0);
    chk("rst_m0_ready", o_m0_ready[0], 32'd0);
    chk("rst_tout", o_tout[1], 32'd0);

    // single m0 read
    cyc();
    m0_valid = 1'b1; m0_addr = 32'h1000_0010; bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("single_idle_gnt", o_gnt[0], 32'd0);
    cyc();
    @(negedge clk);
    chk("single_gnt", o_gnt[0], 32'd1);
    chk("single_m0_ready", o_m0_ready[0], 32'd1);
    chk("single_m0_rdata", o_m0_rdata[0], 32'h1234_5678);
    chk("single_bus_addr", o_bus_addr[0], 32'h1000_0010);
    cyc();
    m0_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("single_back_idle", o_gnt[0], 32'd0);

    // contention with bus always ready
    do_reset();
`ifdef BUS_ARB_RR_EN
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif
    m0_valid = 1'b1; m1_valid = 1'b1; bus_ready = 1'b1;
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("contention_gnt%0d", i), o_gnt[0], 32'(exp_seq[i]));
    end

    // stall lock: m1 write stalled 20 cycles while m0 requests
    do_reset();
    m1_valid = 1'b1; m1_wen = 1'b1; m1_addr = 32'h3000_0000; m1_wdata = 32'hA5A5_0001; m1_wmask = 4'hF;
    cyc();
    m0_valid = 1'b1; m0_addr = 32'h1000_0020;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("stall_gnt%0d", i), o_gnt[0], 32'd2);
      if (i == 0) begin
        chk("stall_bus_wen", o_bus_wen[0], 32'd1);
        chk("stall_bus_addr", o_bus_addr[0], 32'h3000_0000);
      end
      cyc();
    end
    bus_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_m1_ready", o_m1_ready[0], 32'd1);
    cyc();
    m1_valid = 1'b0; m1_wen = 1'b0;
    @(negedge clk);
    chk("stall_switch_gnt", o_gnt[0], 32'd1);

    // timeout on the TIMEOUT_CYC=4 instance
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h1000_0040;
    for (int s = 1; s <= 5; s++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("to_err_s%0d", s), o_tout[1], (s == 5) ? 32'd1 : 32'd0);
      chk($sformatf("to_m0_ready_s%0d", s), o_m0_ready[1], (s == 5) ? 32'd1 : 32'd0);
      chk($sformatf("to_bus_valid_s%0d", s), o_bus_valid[1], (s == 5) ? 32'd0 : 32'd1);
    end
    chk("to_rdata", o_m0_rdata[1], 32'hDEAD_BEEF);
    chk("to_default_inst_quiet", o_tout[0], 32'd0);
    cyc();
    @(negedge clk);
    chk("to_pulse_ends", o_tout[1], 32'd0);
    chk("to_regrant", o_gnt[1], 32'd1);

    // reset during a stalled m1 transfer
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h3000_0010;
    cyc(); cyc(); cyc();
    cyc();
    rst = 1'b1; m0_valid = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_gnt", o_gnt[0], 32'd0);
    chk("midrst_bus_valid", o_bus_valid[0], 32'd0);
    chk("midrst_tout", o_tout[1], 32'd0);
    cyc();
    @(negedge clk);
    chk("midrst_m0_wins", o_gnt[0], 32'd1);

    // abandon: m0 drops valid mid-stall, then a fresh stall must time out after a full count
    do_reset();
    m0_valid = 1'b1;
    cyc(); cyc(); cyc();
    m0_valid = 1'b0;
    @(negedge clk);
    chk("abandon_bus_valid", o_bus_valid[0], 32'd0);
    cyc();
    @(negedge clk);
    chk("abandon_idle", o_gnt[0], 32'd0);
    chk("abandon_tout", o_tout[1], 32'd0);
    m0_valid = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("abandon_to_s%0d", s), o_tout[1], (s == 5) ? 32'd1 : 32'd0);
    end

    // mixed traffic checked by the model alone
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cyc();
      rst       = ($urandom_range(0, 59) == 0);
      m0_valid  = ($urandom_range(0, 3) != 0);
      m1_valid  = ($urandom_range(0, 3) != 0);
      m0_wen    = $urandom_range(0, 1) != 0;
      m1_wen    = $urandom_range(0, 1) != 0;
      m0_addr   = $urandom; m1_addr = $urandom;
      m0_wdata  = $urandom; m1_wdata = $urandom;
      m0_wmask  = 4'($urandom_range(0, 15));
      m1_wmask  = 4'($urandom_range(0, 15));
      bus_ready = ($urandom_range(0, 9) < 3);
      bus_rdata = $urandom;
    end
    cyc();
    rst = 1'b0;
    idle_inputs();
    cyc();
    @(negedge clk);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
